// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared constants for the RAM port arbiter.
// FSM state encoding and requester id values used by ram_port_arbiter
// and its picker sub-module.
package ram_arb_pkg;

  // FSM state encoding
  localparam logic [1:0] ARB_IDLE  = 2'd0;
  localparam logic [1:0] ARB_ISSUE = 2'd1;
  localparam logic [1:0] ARB_CAPT  = 2'd2;

  // Requester ids
  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/ram_arb_pick.sv
// ram_arb_pick: combinational 2-way request picker.
// A lone request always wins; on contention the requester named by
// rr_ptr wins. any_req flags that at least one request is present.
module ram_arb_pick (
  input  logic [1:0] req,
  input  logic       rr_ptr,
  output logic       win_id,
  output logic       any_req
);
  import ram_arb_pkg::*;

  // Pick the winner from the current request levels
  always_comb begin
    any_req = |req;
    if (&req)
      win_id = rr_ptr;
    else if (req[1])
      win_id = REQ1;
    else
      win_id = REQ0;
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one port of a synchronous-read RAM between
// two requesters with a req/gnt/rvalid handshake. Each access takes
// three cycles: IDLE (arbitrate and latch) -> ISSUE (drive RAM, grant)
// -> CAPT (capture read data). All RAM-side outputs are registered.
// Build option: define RAM_ARB_FIXED_PRIO_EN for fixed priority to
// requester 0 on contention; default is round-robin.
module ram_port_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  r0_req,
  input  logic                  r0_we,
  input  logic [ADDR_WIDTH-1:0] r0_addr,
  input  logic [DATA_WIDTH-1:0] r0_wdata,
  output logic                  r0_gnt,
  output logic                  r0_rvalid,
  output logic [DATA_WIDTH-1:0] r0_rdata,
  input  logic                  r1_req,
  input  logic                  r1_we,
  input  logic [ADDR_WIDTH-1:0] r1_addr,
  input  logic [DATA_WIDTH-1:0] r1_wdata,
  output logic                  r1_gnt,
  output logic                  r1_rvalid,
  output logic [DATA_WIDTH-1:0] r1_rdata,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_q
);
  import ram_arb_pkg::*;

  logic [1:0] state;
  logic       win_id;
  logic       we_lat;
  logic       pick_id;
  logic       any_req;
  logic       prio_sel;

`ifdef RAM_ARB_FIXED_PRIO_EN
  // Requester 0 always takes contention
  assign prio_sel = REQ0;
`else
  logic rr_ptr;

  assign prio_sel = rr_ptr;

  // Round-robin pointer: next contention goes to the requester that lost this one
  always_ff @(posedge clk) begin
    if (!reset_n)
      rr_ptr <= REQ0;
    else if (state == ARB_ISSUE)
      rr_ptr <= ~win_id;
  end
`endif

  ram_arb_pick u_pick (
    .req     ({r1_req, r0_req}),
    .rr_ptr  (prio_sel),
    .win_id  (pick_id),
    .any_req (any_req)
  );

  // Access sequencer: latch the winner in IDLE, grant in ISSUE, capture in CAPT
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= ARB_IDLE;
      win_id    <= REQ0;
      we_lat    <= 1'b0;
      ram_addr  <= '0;
      ram_data  <= '0;
      ram_we    <= 1'b0;
      r0_gnt    <= 1'b0;
      r1_gnt    <= 1'b0;
      r0_rvalid <= 1'b0;
      r1_rvalid <= 1'b0;
      r0_rdata  <= '0;
      r1_rdata  <= '0;
    end else begin
      // Pulses default low; each is raised for exactly one cycle below
      r0_gnt    <= 1'b0;
      r1_gnt    <= 1'b0;
      r0_rvalid <= 1'b0;
      r1_rvalid <= 1'b0;
      ram_we    <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (any_req) begin
            win_id <= pick_id;
            state  <= ARB_ISSUE;
            if (pick_id == REQ1) begin
              ram_addr <= r1_addr;
              ram_data <= r1_wdata;
              ram_we   <= r1_we;
              we_lat   <= r1_we;
              r1_gnt   <= 1'b1;
            end else begin
              ram_addr <= r0_addr;
              ram_data <= r0_wdata;
              ram_we   <= r0_we;
              we_lat   <= r0_we;
              r0_gnt   <= 1'b1;
            end
          end
        end
        ARB_ISSUE: begin
          // RAM samples the address at the end of this cycle; q is valid in CAPT
          state <= ARB_CAPT;
        end
        ARB_CAPT: begin
          if (!we_lat) begin
            if (win_id == REQ1) begin
              r1_rdata  <= ram_q;
              r1_rvalid <= 1'b1;
            end else begin
              r0_rdata  <= ram_q;
              r0_rvalid <= 1'b1;
            end
          end
          state <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule
